// File: rtl/uart_frame_loader.sv
// +--------------------------------------------------------------------------+
// | uart_frame_loader: sync-byte hunter that loads one IMG_W*IMG_H frame of  |
// | 3-bit pixels from uart_rx into a framebuffer write port. Rev 1.0         |
// +--------------------------------------------------------------------------+
`default_nettype none

module uart_frame_loader #(
  parameter int         IMG_W          = 160,
  parameter int         IMG_H          = 120,
  parameter int         ADDR_W         = 15,
  parameter logic [7:0] SYNC_BYTE      = 8'hA5,
  parameter int         TIMEOUT_CYCLES = 50_000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  input  logic              rx_frame_error,
  output logic              fb_we,
  output logic [ADDR_W-1:0] fb_addr,
  output logic [2:0]        fb_data,
  output logic              busy,
  output logic              frame_done,
  output logic [1:0]        err_code,
  output logic [1:0]        state
);

  localparam int                TO_W     = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [ADDR_W-1:0] LAST_PIX = ADDR_W'(IMG_W * IMG_H - 1);
  localparam logic [TO_W-1:0]   TO_LAST  = TO_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_DONE  = 2'd2,
    S_ERROR = 2'd3
  } state_t;

  state_t            cur_state;
  state_t            nxt_state;
  logic [ADDR_W-1:0] pix_cnt;
  logic [TO_W-1:0]   to_cnt;
  logic              start;
  logic              accept;
  logic              set_err;
  logic [1:0]        nxt_err;

  always_comb begin
    nxt_state = cur_state;
    start     = 1'b0;
    accept    = 1'b0;
    set_err   = 1'b0;
    nxt_err   = 2'd0;
    case (cur_state)
      S_IDLE: begin
        if (rx_valid && (rx_data == SYNC_BYTE)) begin
          start     = 1'b1;
          nxt_state = S_LOAD;
        end
      end
      S_LOAD: begin
        // A framing error discards any byte strobed in the same cycle.
        if (rx_frame_error) begin
          set_err   = 1'b1;
          nxt_err   = 2'd1;
          nxt_state = S_ERROR;
        end else if (rx_valid) begin
          if (rx_data <= 8'd7) begin
            accept = 1'b1;
            if (pix_cnt == LAST_PIX) nxt_state = S_DONE;
          end else begin
            set_err   = 1'b1;
            nxt_err   = 2'd2;
            nxt_state = S_ERROR;
          end
        end else if (to_cnt == TO_LAST) begin
          set_err   = 1'b1;
          nxt_err   = 2'd3;
          nxt_state = S_ERROR;
        end
      end
      S_DONE:  nxt_state = S_IDLE;
      S_ERROR: nxt_state = S_IDLE;
      default: nxt_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cur_state <= S_IDLE;
    else        cur_state <= nxt_state;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fb_we      <= 1'b0;
      fb_addr    <= '0;
      fb_data    <= 3'd0;
      frame_done <= 1'b0;
      err_code   <= 2'd0;
      pix_cnt    <= '0;
      to_cnt     <= '0;
    end else begin
      fb_we      <= accept;
      frame_done <= (cur_state == S_DONE);
      if (accept) begin
        fb_addr <= pix_cnt;
        fb_data <= rx_data[2:0];
      end
      // The counter parks at zero after the last pixel so it never exceeds N-1.
      if (start) begin
        err_code <= 2'd0;
        pix_cnt  <= '0;
        to_cnt   <= '0;
      end else if (accept) begin
        pix_cnt <= (pix_cnt == LAST_PIX) ? '0 : pix_cnt + ADDR_W'(1);
        to_cnt  <= '0;
      end else if (cur_state == S_LOAD) begin
        to_cnt <= to_cnt + TO_W'(1);
      end
      if (set_err) err_code <= nxt_err;
    end
  end

  assign busy  = (cur_state == S_LOAD);
  assign state = cur_state;

endmodule

`default_nettype wire
